// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: opcodes, FSM state
// encoding and opcode-class helpers.
package cpu_pkg;

  localparam int ISA_OPW = 4;

  localparam logic [ISA_OPW-1:0] OP_ADD    = 4'h0;
  localparam logic [ISA_OPW-1:0] OP_PADDSB = 4'h1;
  localparam logic [ISA_OPW-1:0] OP_SUB    = 4'h2;
  localparam logic [ISA_OPW-1:0] OP_XOR    = 4'h3;
  localparam logic [ISA_OPW-1:0] OP_SLL    = 4'h4;
  localparam logic [ISA_OPW-1:0] OP_SRA    = 4'h5;
  localparam logic [ISA_OPW-1:0] OP_ROR    = 4'h6;
  localparam logic [ISA_OPW-1:0] OP_RED    = 4'h7;
  localparam logic [ISA_OPW-1:0] OP_LW     = 4'h8;
  localparam logic [ISA_OPW-1:0] OP_SW     = 4'h9;
  localparam logic [ISA_OPW-1:0] OP_LLB    = 4'hA;
  localparam logic [ISA_OPW-1:0] OP_LHB    = 4'hB;
  localparam logic [ISA_OPW-1:0] OP_B      = 4'hC;
  localparam logic [ISA_OPW-1:0] OP_BR     = 4'hD;
  localparam logic [ISA_OPW-1:0] OP_PCS    = 4'hE;
  localparam logic [ISA_OPW-1:0] OP_HLT    = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_t;

  function automatic logic is_alu_op(input logic [ISA_OPW-1:0] op);
    return ~op[ISA_OPW-1];
  endfunction

  function automatic logic is_mem_op(input logic [ISA_OPW-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_branch(input logic [ISA_OPW-1:0] op);
    return (op == OP_B) || (op == OP_BR);
  endfunction

endpackage

// File: rtl/cpu_seq_perf.sv
// Free-running performance counters for the sequencer (active cycles and
// retired instructions). Present only when SEQ_PERF_CNT_EN is defined.
`ifdef SEQ_PERF_CNT_EN
module cpu_seq_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        retire,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  // Both counters wrap naturally at 2**32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (active) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instr_cnt <= instr_cnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: owns the shared memory port and the
// IR/PC/RF strobes. Optional perf counters under SEQ_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | out of reset, start fetching next cycle
// FETCH  | instruction read at PC, wait for mem_ready
// DECODE | latch opcode, trap HLT
// EXEC   | ALU step; branches resolve and retire here
// MEM    | LW/SW data access, wait for mem_ready
// WB     | register-file write, retire
// HALT   | parked until reset (HLT or memory timeout)
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW          = 4,
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAITW        = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           br_taken,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           mem_is_data,
  output logic           ir_load,
  output logic           pc_write,
  output logic           pc_src,
  output logic           rf_write,
  output logic           retire,
  output logic           halted,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]    cycle_cnt,
  output logic [31:0]    instr_cnt,
`endif
  output logic           mem_err
);

  localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(MEM_WAIT_MAX - 1);
  localparam logic [WAITW-1:0] WAIT_SAT  = WAITW'(MEM_WAIT_MAX);

  seq_state_t       state_q, state_d;
  logic [OPW-1:0]   op_q;
  logic [WAITW-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q;
  logic             timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_q | timeout;
      if (state_q == ST_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_is_data = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    rf_write    = 1'b0;
    retire      = 1'b0;
    halted      = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          timeout = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_HLT) begin
          retire  = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_branch(op_q)) begin
          pc_write = br_taken;
          pc_src   = 1'b1;
          retire   = 1'b1;
          state_d  = ST_FETCH;
        end else if (is_mem_op(op_q)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req     = 1'b1;
        mem_is_data = 1'b1;
        mem_we      = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_cnt_q >= WAIT_LAST) begin
          timeout = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_WB: begin
        rf_write = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counts stalled request cycles of the current access; saturates after a trap.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (((state_d == ST_FETCH) || (state_d == ST_MEM)) && (state_d != state_q))
      wait_cnt_d = '0;
    else if (mem_req && mem_ready)
      wait_cnt_d = '0;
    else if (mem_req && (wait_cnt_q != WAIT_SAT))
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign mem_err = mem_err_q;

`ifdef SEQ_PERF_CNT_EN
  cpu_seq_perf u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    ((state_q != ST_IDLE) && (state_q != ST_HALT)),
    .retire    (retire),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: random programs and memory latencies,
// per-instruction expectations from a cycle-count model of the ISA flow.
module tb_cpu_sequencer;

  typedef struct {
    int lat; int rf; int pcw; int pcs; int we; int req; int ir;
    bit hlt; bit tmo;
  } exp_t;

  typedef struct { logic [3:0] op; bit br; } ins_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic mem_req, mem_we, mem_is_data, ir_load, pc_write, pc_src;
  logic rf_write, retire, halted, mem_err;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_is_data(mem_is_data), .ir_load(ir_load), .pc_write(pc_write),
    .pc_src(pc_src), .rf_write(rf_write), .retire(retire),
    .halted(halted), .mem_err(mem_err)
  );

  int   total = 0;
  int   bad = 0;
  exp_t eq[$];
  ins_t oq[$];
  int   dq[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: cycle/strobe totals of one instruction from fetch start to retire.
  function automatic exp_t model(input logic [3:0] op, input bit br, input int fd, input int md);
    exp_t e;
    e.lat = 0; e.rf = 0; e.pcw = 1; e.pcs = 0; e.we = 0;
    e.req = fd + 1; e.ir = 1; e.hlt = 0; e.tmo = 0;
    if (op == 4'hF) begin
      e.lat = fd + 2; e.hlt = 1;
    end else if (op == 4'h8) begin
      e.lat = fd + md + 5; e.rf = 1; e.req += md + 1;
    end else if (op == 4'h9) begin
      e.lat = fd + md + 4; e.we = md + 1; e.req += md + 1;
    end else if (op == 4'hC || op == 4'hD) begin
      e.lat = fd + 3; e.pcw += int'(br); e.pcs = int'(br);
    end else begin
      e.lat = fd + 4; e.rf = 1;
    end
    return e;
  endfunction

  // Memory responder: each access completes after its queued number of stall cycles.
  initial begin
    bit busy = 0;
    int age = 0;
    int cur = 0;
    ins_t ni;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        busy = 0; mem_ready = 1'b0;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1; age = 0;
          cur = (dq.size() > 0) ? dq.pop_front() : 0;
        end
        if (age == cur) begin
          mem_ready = 1'b1; busy = 0;
          if (!mem_is_data && oq.size() > 0) begin
            ni = oq.pop_front();
            opcode = ni.op; br_taken = ni.br;
          end
        end else begin
          mem_ready = 1'b0; age++;
        end
      end else begin
        busy = 0;
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: accumulates strobes per instruction and checks on retire/halt.
  initial begin
    bit in_instr = 0, expect_fetch = 0, pend_hlt = 0, halt_seen = 0;
    int lat = 0, rf = 0, pcw = 0, pcs = 0, we = 0, req = 0, ir = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_instr = 0; expect_fetch = 0; pend_hlt = 0; halt_seen = 0;
      end else begin
        if (pend_hlt) begin
          chk("hlt_halted", int'(halted), 1);
          pend_hlt = 0;
        end
        if (expect_fetch) begin
          chk("next_fetch", int'(mem_req && !mem_is_data), 1);
          expect_fetch = 0;
        end
        if (!in_instr && mem_req && !mem_is_data) begin
          in_instr = 1;
          lat = 0; rf = 0; pcw = 0; pcs = 0; we = 0; req = 0; ir = 0;
        end
        if (in_instr) begin
          lat++;
          rf  += int'(rf_write);
          pcw += int'(pc_write);
          pcs += int'(pc_write && pc_src);
          we  += int'(mem_we);
          req += int'(mem_req);
          ir  += int'(ir_load);
        end
        if (retire) begin
          if (eq.size() == 0) begin
            chk("unexpected_retire", 1, 0);
          end else begin
            e = eq.pop_front();
            chk("latency", lat, e.lat);
            chk("rf_write_cnt", rf, e.rf);
            chk("pc_write_cnt", pcw, e.pcw);
            chk("pc_src_cnt", pcs, e.pcs);
            chk("mem_we_cnt", we, e.we);
            chk("mem_req_cnt", req, e.req);
            chk("ir_load_cnt", ir, e.ir);
            if (e.hlt) pend_hlt = 1; else expect_fetch = 1;
          end
          in_instr = 0;
        end
        if (halted && !halt_seen) begin
          halt_seen = 1;
          if (in_instr) begin
            if (eq.size() == 0) begin
              chk("unexpected_halt", 1, 0);
            end else begin
              e = eq.pop_front();
              chk("timeout_expected", 1, int'(e.tmo));
              chk("tmo_mem_req_cnt", req, e.req);
              chk("tmo_pc_write_cnt", pcw, e.pcw);
              chk("tmo_mem_we_cnt", we, e.we);
              chk("tmo_rf_write_cnt", rf, e.rf);
              chk("tmo_ir_load_cnt", ir, e.ir);
              chk("tmo_mem_err", int'(mem_err), 1);
            end
            in_instr = 0;
          end else begin
            chk("hlt_no_mem_err", int'(mem_err), 0);
          end
        end
        if (halted) begin
          chk("halt_strobes", int'({mem_req, mem_we, mem_is_data, ir_load,
                                    pc_write, pc_src, rf_write, retire}), 0);
        end
      end
    end
  end

  task automatic push_instr(input logic [3:0] op, input bit br, input int fd,
                            input int md, input bit with_exp);
    ins_t i;
    i.op = op; i.br = br;
    oq.push_back(i);
    dq.push_back(fd);
    if (op == 4'h8 || op == 4'h9) dq.push_back(md);
    if (with_exp) eq.push_back(model(op, br, fd, md));
  endtask

  task automatic assert_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs_zero", int'({mem_req, mem_we, mem_is_data, ir_load, pc_write,
                                    pc_src, rf_write, retire, halted, mem_err}), 0);
    eq.delete(); oq.delete(); dq.delete();
  endtask

  task automatic release_reset();
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #4;
    chk("idle_to_fetch", int'(mem_req && !mem_is_data), 1);
  endtask

  function automatic int pick_delay();
    return ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
  endfunction

  initial begin
    logic [3:0] op;
    int   n, fd, md, kind;
    bit   done;
    exp_t t;
    for (int run = 0; run < 8; run++) begin
      kind = run % 4;
      assert_reset();
      repeat (2) @(posedge clk);
      if (run == 0) begin
        push_instr(4'h0, 0, 0, 0, 1);
        push_instr(4'h8, 0, 0, 3, 1);
        push_instr(4'h9, 0, 0, 0, 1);
        push_instr(4'hC, 1, 0, 0, 1);
        push_instr(4'hD, 0, 0, 0, 1);
        push_instr(4'h0, 0, 14, 0, 1);
        push_instr(4'h9, 0, 1, 14, 1);
      end
      n = $urandom_range(5, 10);
      for (int i = 0; i < n; i++) begin
        op = 4'($urandom_range(0, 14));
        push_instr(op, 1'($urandom_range(0, 1)), pick_delay(), pick_delay(), 1);
      end
      fd = $urandom_range(0, 3);
      case (kind)
        0: push_instr(4'hF, 0, fd, 0, 1);
        1: begin
          dq.push_back(100);
          t.lat = 0; t.rf = 0; t.pcw = 0; t.pcs = 0; t.we = 0;
          t.req = 15; t.ir = 0; t.hlt = 0; t.tmo = 1;
          eq.push_back(t);
        end
        2: begin
          op = ($urandom_range(0, 1) == 1) ? 4'h9 : 4'h8;
          push_instr(op, 0, fd, 100, 0);
          t.lat = 0; t.rf = 0; t.pcw = 1; t.pcs = 0;
          t.we = (op == 4'h9) ? 15 : 0;
          t.req = fd + 1 + 15; t.ir = 1; t.hlt = 0; t.tmo = 1;
          eq.push_back(t);
        end
        default: push_instr(4'h8, 0, fd, 8, 0);
      endcase
      release_reset();
      done = 0;
      for (int c = 0; c < 3000 && !done; c++) begin
        @(posedge clk); #2;
        if (kind == 3) done = mem_req && mem_is_data && (eq.size() == 0);
        else           done = halted;
      end
      chk("run_end_reached", int'(done), 1);
      if (kind == 3) begin
        repeat (2) @(posedge clk);
        #2;
        chk("mid_mem_not_halted", int'(halted), 0);
        chk("mid_mem_still_req", int'(mem_req && mem_is_data), 1);
      end else begin
        repeat (6) @(posedge clk);
        #2;
        chk("halt_sticky", int'(halted), 1);
        chk("mem_err_value", int'(mem_err), (kind == 0) ? 0 : 1);
      end
      chk("queue_drained", eq.size(), 0);
    end
    assert_reset();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
